// File: rtl/data_memory_backing.sv
// data_memory_backing: whole-line backing store behind the data cache, fixed-latency enable/ack handshake
module data_memory_backing #(
    parameter int LATENCY    = 10,
    parameter int DEPTH_LOG2 = 9,
    parameter int LINE_W     = 256
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [31:0]       addr_i,
    input  logic [LINE_W-1:0] data_i,
    input  logic              enable_i,
    input  logic              write_i,
    output logic              ack_o,
    output logic [LINE_W-1:0] data_o
);
    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam int CNT_W = $clog2(LATENCY + 1);

    typedef enum logic [1:0] {IDLE, BUSY, ACK} state_t;

    logic [LINE_W-1:0] memory [0:DEPTH-1];

    state_t                state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [DEPTH_LOG2-1:0] idx_q, idx_d;
    logic [LINE_W-1:0]     wdata_q, wdata_d;
    logic                  write_q, write_d;
    logic                  ack_q, ack_d;
    logic [LINE_W-1:0]     data_q, data_d;
    logic                  last;
    logic                  mem_we;
    logic                  unused_addr_bits;

    // Offset bits and bits above the 16 KB window do not select a line.
    assign unused_addr_bits = ^{addr_i[31:5+DEPTH_LOG2], addr_i[4:0]};

    assign last   = (state_q == BUSY) && (cnt_q == CNT_W'(LATENCY - 1));
    assign mem_we = last && write_q;
    assign ack_o  = ack_q;
    assign data_o = data_q;

    // Next-state logic: latch the request at acceptance, count out the latency, pulse ack once.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        wdata_d = wdata_q;
        write_d = write_q;
        ack_d   = 1'b0;
        data_d  = data_q;
        case (state_q)
            IDLE: if (enable_i) begin
                state_d = BUSY;
                cnt_d   = CNT_W'(1);
                idx_d   = addr_i[5+DEPTH_LOG2-1:5];
                wdata_d = data_i;
                write_d = write_i;
            end
            BUSY: if (last) begin
                state_d = ACK;
                ack_d   = 1'b1;
                data_d  = write_q ? data_q : memory[idx_q];
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
            ACK: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
            default: state_d = IDLE;
        endcase
    end

    // Control and output registers; reset aborts any request in flight.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            wdata_q <= '0;
            write_q <= 1'b0;
            ack_q   <= 1'b0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            wdata_q <= wdata_d;
            write_q <= write_d;
            ack_q   <= ack_d;
            data_q  <= data_d;
        end
    end

    // Line storage is never cleared; a write lands on the same edge that raises ack.
    always_ff @(posedge clk_i) begin
        if (mem_we && rst_i) memory[idx_q] <= wdata_q;
    end
endmodule

// File: tb/tb_data_memory_backing.sv
// tb_data_memory_backing: directed checks of latency, aliasing, reset abort, back-to-back and input latching
module tb_data_memory_backing;
    localparam int LAT = 10;
    localparam logic [255:0] P0  = 256'h0000_1111_2222_3333_4444_5555_6666_7777_8888_9999_AAAA_BBBB_CCCC_DDDD_EEEE_FFFF;
    localparam logic [255:0] W   = {16{16'hECFA}};
    localparam logic [255:0] M32 = {8{32'hDEADBEEF}};
    localparam logic [255:0] M4  = {8{32'h0BADF00D}};
    localparam logic [255:0] A   = {8{32'h12345678}};
    localparam logic [255:0] B   = {8{32'h87654321}};

    logic         clk_i;
    logic         rst_i;
    logic [31:0]  addr_i;
    logic [255:0] data_i;
    logic         enable_i;
    logic         write_i;
    logic         ack_o;
    logic [255:0] data_o;

    int errors = 0;
    int checks = 0;

    data_memory_backing #(.LATENCY(LAT), .DEPTH_LOG2(9), .LINE_W(256)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .addr_i(addr_i), .data_i(data_i),
        .enable_i(enable_i), .write_i(write_i), .ack_o(ack_o), .data_o(data_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    // Issue one request and wait for ack; lat = edges after the accepting edge, -1 on timeout.
    task automatic run_req(input logic [31:0] a, input logic [255:0] d, input logic w, output int lat);
        addr_i = a; data_i = d; write_i = w; enable_i = 1'b1;
        step();
        lat = -1;
        for (int n = 1; n <= 40; n++) begin
            step();
            if (ack_o) begin
                lat = n;
                break;
            end
        end
        enable_i = 1'b0;
    endtask

    task automatic test_reset();
        rst_i = 1'b1; enable_i = 1'b0; write_i = 1'b0; addr_i = '0; data_i = '0;
        #2 rst_i = 1'b0;
        repeat (3) @(posedge clk_i);
        #1;
        checks++; if (ack_o !== 1'b0) begin errors++; $display("FAIL reset_ack got=%b exp=0", ack_o); end
        checks++; if (data_o !== '0) begin errors++; $display("FAIL reset_data got=%h exp=0", data_o); end
        rst_i = 1'b1;
        step();
    endtask

    task automatic test_read_preload();
        int lat;
        dut.memory[0] = P0;
        run_req(32'h0, '0, 1'b0, lat);
        checks++; if (lat !== LAT - 1) begin errors++; $display("FAIL read_latency got=%0d exp=%0d", lat, LAT - 1); end
        checks++; if (data_o !== P0) begin errors++; $display("FAIL read_data got=%h exp=%h", data_o, P0); end
        step();
        checks++; if (ack_o !== 1'b0) begin errors++; $display("FAIL read_ack_pulse got=%b exp=0", ack_o); end
        checks++; if (data_o !== P0) begin errors++; $display("FAIL read_data_hold got=%h exp=%h", data_o, P0); end
    endtask

    task automatic test_write();
        int lat;
        run_req(32'h240, W, 1'b1, lat);
        checks++; if (lat !== LAT - 1) begin errors++; $display("FAIL write_latency got=%0d exp=%0d", lat, LAT - 1); end
        checks++; if (dut.memory[18] !== W) begin errors++; $display("FAIL write_mem18 got=%h exp=%h", dut.memory[18], W); end
        checks++; if (data_o !== P0) begin errors++; $display("FAIL write_data_o_kept got=%h exp=%h", data_o, P0); end
        step();
        run_req(32'h240, '0, 1'b0, lat);
        checks++; if (data_o !== W) begin errors++; $display("FAIL write_readback got=%h exp=%h", data_o, W); end
        step();
    endtask

    task automatic test_alias();
        int lat;
        run_req(32'h401F, '0, 1'b0, lat);
        checks++; if (lat !== LAT - 1) begin errors++; $display("FAIL alias_latency got=%0d exp=%0d", lat, LAT - 1); end
        checks++; if (data_o !== P0) begin errors++; $display("FAIL alias_data got=%h exp=%h", data_o, P0); end
        step();
    endtask

    task automatic test_reset_mid();
        int lat;
        logic saw_ack;
        dut.memory[32] = M32;
        addr_i = 32'h400; data_i = {32{8'h5A}}; write_i = 1'b1; enable_i = 1'b1;
        step();
        repeat (5) step();
        rst_i = 1'b0;
        #1;
        enable_i = 1'b0;
        checks++; if (ack_o !== 1'b0) begin errors++; $display("FAIL rstmid_ack got=%b exp=0", ack_o); end
        checks++; if (data_o !== '0) begin errors++; $display("FAIL rstmid_data got=%h exp=0", data_o); end
        saw_ack = 1'b0;
        repeat (12) begin
            @(posedge clk_i);
            #1;
            if (ack_o) saw_ack = 1'b1;
        end
        rst_i = 1'b1;
        step();
        checks++; if (saw_ack !== 1'b0) begin errors++; $display("FAIL rstmid_no_ack got=%b exp=0", saw_ack); end
        checks++; if (dut.memory[32] !== M32) begin errors++; $display("FAIL rstmid_mem32 got=%h exp=%h", dut.memory[32], M32); end
        run_req(32'h400, '0, 1'b0, lat);
        checks++; if (lat !== LAT - 1) begin errors++; $display("FAIL rstmid_idle_latency got=%0d exp=%0d", lat, LAT - 1); end
        checks++; if (data_o !== M32) begin errors++; $display("FAIL rstmid_read got=%h exp=%h", data_o, M32); end
        step();
    endtask

    task automatic test_back_to_back();
        int pulses, first_pos, second_pos;
        logic [255:0] first_data;
        logic ack_after_first;
        pulses = 0; first_pos = -1; second_pos = -1; first_data = '0; ack_after_first = 1'bx;
        addr_i = 32'h240; data_i = '0; write_i = 1'b0; enable_i = 1'b1;
        step();
        for (int n = 1; n <= 25; n++) begin
            step();
            if (n == first_pos + 1 && first_pos > 0) ack_after_first = ack_o;
            if (ack_o) begin
                pulses++;
                if (pulses == 1) begin first_pos = n; first_data = data_o; addr_i = 32'h0; end
                if (pulses == 2) begin second_pos = n; enable_i = 1'b0; end
            end
        end
        checks++; if (pulses !== 2) begin errors++; $display("FAIL b2b_pulses got=%0d exp=2", pulses); end
        checks++; if (first_pos !== LAT - 1) begin errors++; $display("FAIL b2b_first got=%0d exp=%0d", first_pos, LAT - 1); end
        checks++; if (ack_after_first !== 1'b0) begin errors++; $display("FAIL b2b_ack_drop got=%b exp=0", ack_after_first); end
        checks++; if (second_pos !== 2 * LAT) begin errors++; $display("FAIL b2b_second got=%0d exp=%0d", second_pos, 2 * LAT); end
        checks++; if (first_data !== W) begin errors++; $display("FAIL b2b_first_data got=%h exp=%h", first_data, W); end
        checks++; if (data_o !== P0) begin errors++; $display("FAIL b2b_second_data got=%h exp=%h", data_o, P0); end
    endtask

    task automatic test_busy_change();
        int lat;
        dut.memory[4] = M4;
        addr_i = 32'h60; data_i = A; write_i = 1'b1; enable_i = 1'b1;
        step();
        addr_i = 32'h80; data_i = B; write_i = 1'b0;
        lat = -1;
        for (int n = 1; n <= 40; n++) begin
            step();
            if (ack_o) begin lat = n; break; end
        end
        enable_i = 1'b0;
        checks++; if (lat !== LAT - 1) begin errors++; $display("FAIL busy_latency got=%0d exp=%0d", lat, LAT - 1); end
        checks++; if (dut.memory[3] !== A) begin errors++; $display("FAIL busy_mem3 got=%h exp=%h", dut.memory[3], A); end
        checks++; if (dut.memory[4] !== M4) begin errors++; $display("FAIL busy_mem4 got=%h exp=%h", dut.memory[4], M4); end
        checks++; if (data_o !== P0) begin errors++; $display("FAIL busy_data_o_kept got=%h exp=%h", data_o, P0); end
        step();
        addr_i = 32'h60; data_i = '0; write_i = 1'b0; enable_i = 1'b1;
        step();
        addr_i = 32'h80; data_i = B; write_i = 1'b1;
        lat = -1;
        for (int n = 1; n <= 40; n++) begin
            step();
            if (ack_o) begin lat = n; break; end
        end
        enable_i = 1'b0;
        checks++; if (data_o !== A) begin errors++; $display("FAIL busy_read_data got=%h exp=%h", data_o, A); end
        checks++; if (dut.memory[4] !== M4) begin errors++; $display("FAIL busy_read_mem4 got=%h exp=%h", dut.memory[4], M4); end
        step();
    endtask

    initial begin
        test_reset();
        test_read_preload();
        test_write();
        test_alias();
        test_reset_mid();
        test_back_to_back();
        test_busy_change();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
